wb_serializer: RTL and testbench

Parametrised write-back serializer for the compute datapath. It captures N_CH result words from the MU outputs on a single strobe, then writes them to the result RAM one word per cycle at consecutive addresses. Each word is sign- or zero-extended to the RAM data width. Relative to the previous write-back block, it adds:
- a loadable, wrapping address pointer;
- a RAM stall input;
- back-to-back batch acceptance;
- busy, done and drop reporting.

---
 rtl/wb_serializer.sv | 135 +++++++++++++
 tb/tb_wb_serializer.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/wb_serializer.sv
// Write-back serializer: captures N_CH channel results on a strobe and writes them
// to the result RAM one word per cycle at consecutive (wrapping) addresses.
module wb_serializer #(
    parameter int N_CH   = 4,
    parameter int DW     = 18,
    parameter int RAM_DW = 32,
    parameter int AW     = 8,
    parameter int SEXT   = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 web,
    input  logic [N_CH*DW-1:0]   mu_in,
    input  logic                 addr_load,
    input  logic [AW-1:0]        base_addr,
    input  logic                 wr_stall,
    output logic                 we_n,
    output logic [AW-1:0]        w_addr,
    output logic [RAM_DW-1:0]    dataRAM,
    output logic                 wb_busy,
    output logic                 wb_done,
    output logic                 drop_err
);

    localparam int IW = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(N_CH - 1);

    typedef enum logic {IDLE, WRITE} state_t;

    state_t          state, state_next;
    logic [AW-1:0]   ptr, ptr_next, addr_cur;
    logic [IW-1:0]   idx, idx_next;
    logic [DW-1:0]   buffer [N_CH];
    logic [DW-1:0]   word;
    logic            capture, issue, last_done, drop;

    function automatic logic [RAM_DW-1:0] extend(input logic [DW-1:0] w);
        logic [RAM_DW-1:0] r;
        r = '0;
        r[DW-1:0] = w;
        for (int i = DW; i < RAM_DW; i++) begin
            r[i] = (SEXT != 0) ? w[DW-1] : 1'b0;
        end
        return r;
    endfunction

    // The strobe cycle issues word 0 straight from mu_in so the first write lands
    // one cycle after the strobe; later words come from the captured buffer.
    always_comb begin
        state_next = state;
        ptr_next   = ptr;
        idx_next   = idx;
        addr_cur   = ptr;
        word       = buffer[idx];
        capture    = 1'b0;
        issue      = 1'b0;
        last_done  = 1'b0;
        drop       = 1'b0;
        case (state)
            IDLE: begin
                if (addr_load) begin
                    addr_cur = base_addr;
                    ptr_next = base_addr;
                end
                if (web) begin
                    capture    = 1'b1;
                    state_next = WRITE;
                    word       = mu_in[DW-1:0];
                    idx_next   = '0;
                    if (!wr_stall) begin
                        issue    = 1'b1;
                        idx_next = IW'(1);
                        ptr_next = addr_cur + 1'b1;
                    end
                end
            end
            WRITE: begin
                if (!wr_stall) begin
                    issue    = 1'b1;
                    ptr_next = ptr + 1'b1;
                    idx_next = idx + 1'b1;
                    if (idx == LAST_IDX) begin
                        last_done = 1'b1;
                        idx_next  = '0;
                        if (web) begin
                            capture = 1'b1;
                        end else begin
                            state_next = IDLE;
                        end
                    end
                end
                if (web && !last_done) begin
                    drop = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            ptr      <= '0;
            idx      <= '0;
            we_n     <= 1'b1;
            w_addr   <= '0;
            dataRAM  <= '0;
            wb_busy  <= 1'b0;
            wb_done  <= 1'b0;
            drop_err <= 1'b0;
            for (int k = 0; k < N_CH; k++) begin
                buffer[k] <= '0;
            end
        end else begin
            state    <= state_next;
            ptr      <= ptr_next;
            idx      <= idx_next;
            we_n     <= !issue;
            wb_busy  <= (state_next == WRITE);
            wb_done  <= last_done;
            drop_err <= drop;
            // Address and data stay put while stalled or idle.
            if (issue) begin
                w_addr  <= addr_cur;
                dataRAM <= extend(word);
            end
            if (capture) begin
                for (int k = 0; k < N_CH; k++) begin
                    buffer[k] <= mu_in[k*DW +: DW];
                end
            end
        end
    end

endmodule

// File: tb/tb_wb_serializer.sv
// Directed bench for wb_serializer: zero- and sign-extending instances driven in
// parallel through batch, back-to-back, drop, stall, wrap and mid-batch reset cases.
module tb_wb_serializer;

    localparam int N_CH = 4;
    localparam int DW   = 18;
    localparam int RDW  = 32;
    localparam int AW   = 8;

    logic                clk = 1'b0;
    logic                rst;
    logic                web;
    logic [N_CH*DW-1:0]  mu_in;
    logic                addr_load;
    logic [AW-1:0]       base_addr;
    logic                wr_stall;

    logic                we_n0, we_n1;
    logic [AW-1:0]       w_addr0, w_addr1;
    logic [RDW-1:0]      data0, data1;
    logic                busy0, busy1, done0, done1, drop0, drop1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    wb_serializer #(.N_CH(N_CH), .DW(DW), .RAM_DW(RDW), .AW(AW), .SEXT(0)) u_zext (
        .clk(clk), .rst(rst), .web(web), .mu_in(mu_in), .addr_load(addr_load),
        .base_addr(base_addr), .wr_stall(wr_stall), .we_n(we_n0), .w_addr(w_addr0),
        .dataRAM(data0), .wb_busy(busy0), .wb_done(done0), .drop_err(drop0)
    );

    wb_serializer #(.N_CH(N_CH), .DW(DW), .RAM_DW(RDW), .AW(AW), .SEXT(1)) u_sext (
        .clk(clk), .rst(rst), .web(web), .mu_in(mu_in), .addr_load(addr_load),
        .base_addr(base_addr), .wr_stall(wr_stall), .we_n(we_n1), .w_addr(w_addr1),
        .dataRAM(data1), .wb_busy(busy1), .wb_done(done1), .drop_err(drop1)
    );

    function automatic logic [N_CH*DW-1:0] pack(input logic [DW-1:0] c0, input logic [DW-1:0] c1,
                                                 input logic [DW-1:0] c2, input logic [DW-1:0] c3);
        return {c3, c2, c1, c0};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One write on the zero-extending instance, plus the wb_done/drop_err flags.
    task automatic expectWrite(input string tag, input logic [AW-1:0] addr, input logic [31:0] data,
                               input logic done, input logic drop);
        checkOutput({tag, " we_n"}, 32'(we_n0), 32'd0);
        checkOutput({tag, " w_addr"}, 32'(w_addr0), 32'(addr));
        checkOutput({tag, " dataRAM"}, data0, data);
        checkOutput({tag, " wb_done"}, 32'(done0), 32'(done));
        checkOutput({tag, " drop_err"}, 32'(drop0), 32'(drop));
    endtask

    task automatic expectHold(input string tag, input logic [AW-1:0] addr, input logic [31:0] data);
        checkOutput({tag, " we_n"}, 32'(we_n0), 32'd1);
        checkOutput({tag, " w_addr"}, 32'(w_addr0), 32'(addr));
        checkOutput({tag, " dataRAM"}, data0, data);
        checkOutput({tag, " wb_done"}, 32'(done0), 32'd0);
    endtask

    // Drive inputs, then let one rising edge pass and settle 1 time unit after it.
    task automatic applyStimulus(input logic w, input logic [N_CH*DW-1:0] m, input logic ld,
                                 input logic [AW-1:0] base, input logic stall);
        web       = w;
        mu_in     = m;
        addr_load = ld;
        base_addr = base;
        wr_stall  = stall;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog timeout observed=running expected=finished");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        rst = 1'b1;
        web = 1'b0; mu_in = '0; addr_load = 1'b0; base_addr = '0; wr_stall = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset we_n", 32'(we_n0), 32'd1);
        checkOutput("reset w_addr", 32'(w_addr0), 32'd0);
        checkOutput("reset dataRAM", data0, 32'd0);
        checkOutput("reset wb_busy", 32'(busy0), 32'd0);
        checkOutput("reset wb_done", 32'(done0), 32'd0);
        checkOutput("reset drop_err", 32'(drop0), 32'd0);
        rst = 1'b0;

        $display("[TB] basic batch and sign extension");
        applyStimulus(1'b0, '0, 1'b1, 8'h10, 1'b0);
        checkOutput("load idle we_n", 32'(we_n0), 32'd1);
        applyStimulus(1'b1, pack(18'h00001, 18'h00002, 18'h3FFFF, 18'h20000), 1'b0, 8'h00, 1'b0);
        expectWrite("b1 w0", 8'h10, 32'h0000_0001, 1'b0, 1'b0);
        checkOutput("b1 busy", 32'(busy0), 32'd1);
        checkOutput("sext w0", data1, 32'h0000_0001);
        applyStimulus(1'b0, '0, 1'b0, 8'h00, 1'b0);
        expectWrite("b1 w1", 8'h11, 32'h0000_0002, 1'b0, 1'b0);
        checkOutput("sext w1", data1, 32'h0000_0002);
        applyStimulus(1'b0, '0, 1'b0, 8'h00, 1'b0);
        expectWrite("b1 w2", 8'h12, 32'h0003_FFFF, 1'b0, 1'b0);
        checkOutput("sext w2", data1, 32'hFFFF_FFFF);
        applyStimulus(1'b0, '0, 1'b0, 8'h00, 1'b0);
        expectWrite("b1 w3", 8'h13, 32'h0002_0000, 1'b1, 1'b0);
        checkOutput("sext w3", data1, 32'hFFFE_0000);
        applyStimulus(1'b0, '0, 1'b0, 8'h00, 1'b0);
        expectHold("b1 idle", 8'h13, 32'h0002_0000);
        checkOutput("b1 idle busy", 32'(busy0), 32'd0);

        $display("[TB] back-to-back batches and dropped strobe");
        applyStimulus(1'b1, pack(18'h11111, 18'h22222, 18'h33333, 18'h00444), 1'b0, 8'h00, 1'b0);
        expectWrite("b2 w0", 8'h14, 32'h0001_1111, 1'b0, 1'b0);
        applyStimulus(1'b0, '0, 1'b0, 8'h00, 1'b0);
        expectWrite("b2 w1", 8'h15, 32'h0002_2222, 1'b0, 1'b0);
        applyStimulus(1'b0, '0, 1'b0, 8'h00, 1'b0);
        expectWrite("b2 w2", 8'h16, 32'h0003_3333, 1'b0, 1'b0);
        applyStimulus(1'b1, pack(18'h00AAA, 18'h00BBB, 18'h00CCC, 18'h00DDD), 1'b0, 8'h00, 1'b0);
        expectWrite("b2 w3", 8'h17, 32'h0000_0444, 1'b1, 1'b0);
        checkOutput("b2b busy", 32'(busy0), 32'd1);
        applyStimulus(1'b0, '0, 1'b0, 8'h00, 1'b0);
        expectWrite("b3 w0", 8'h18, 32'h0000_0AAA, 1'b0, 1'b0);
        applyStimulus(1'b0, '0, 1'b0, 8'h00, 1'b0);
        expectWrite("b3 w1", 8'h19, 32'h0000_0BBB, 1'b0, 1'b0);
        applyStimulus(1'b1, pack(18'h3FFFF, 18'h3FFFF, 18'h3FFFF, 18'h3FFFF), 1'b1, 8'h80, 1'b0);
        expectWrite("b3 w2 drop", 8'h1A, 32'h0000_0CCC, 1'b0, 1'b1);
        applyStimulus(1'b0, '0, 1'b0, 8'h00, 1'b0);
        expectWrite("b3 w3", 8'h1B, 32'h0000_0DDD, 1'b1, 1'b0);

        $display("[TB] stall on the second word");
        applyStimulus(1'b1, pack(18'h00101, 18'h00202, 18'h00303, 18'h00404), 1'b0, 8'h00, 1'b0);
        expectWrite("b4 w0", 8'h1C, 32'h0000_0101, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, '0, 1'b0, 8'h00, 1'b1);
            expectHold($sformatf("b4 stall%0d", i), 8'h1C, 32'h0000_0101);
        end
        applyStimulus(1'b0, '0, 1'b0, 8'h00, 1'b0);
        expectWrite("b4 w1", 8'h1D, 32'h0000_0202, 1'b0, 1'b0);
        applyStimulus(1'b0, '0, 1'b0, 8'h00, 1'b0);
        expectWrite("b4 w2", 8'h1E, 32'h0000_0303, 1'b0, 1'b0);
        applyStimulus(1'b0, '0, 1'b0, 8'h00, 1'b0);
        expectWrite("b4 w3", 8'h1F, 32'h0000_0404, 1'b1, 1'b0);

        $display("[TB] pointer wrap with load on the strobe cycle");
        applyStimulus(1'b1, pack(18'h00001, 18'h00002, 18'h00003, 18'h00004), 1'b1, 8'hFE, 1'b0);
        expectWrite("wrap w0", 8'hFE, 32'h0000_0001, 1'b0, 1'b0);
        applyStimulus(1'b0, '0, 1'b0, 8'h00, 1'b0);
        expectWrite("wrap w1", 8'hFF, 32'h0000_0002, 1'b0, 1'b0);
        applyStimulus(1'b0, '0, 1'b0, 8'h00, 1'b0);
        expectWrite("wrap w2", 8'h00, 32'h0000_0003, 1'b0, 1'b0);
        applyStimulus(1'b0, '0, 1'b0, 8'h00, 1'b0);
        expectWrite("wrap w3", 8'h01, 32'h0000_0004, 1'b1, 1'b0);

        $display("[TB] reset in the middle of a batch");
        applyStimulus(1'b1, pack(18'h00005, 18'h00006, 18'h00007, 18'h00008), 1'b0, 8'h00, 1'b0);
        expectWrite("rst w0", 8'h02, 32'h0000_0005, 1'b0, 1'b0);
        applyStimulus(1'b0, '0, 1'b0, 8'h00, 1'b0);
        expectWrite("rst w1", 8'h03, 32'h0000_0006, 1'b0, 1'b0);
        #2 rst = 1'b1;
        #1;
        checkOutput("async rst we_n", 32'(we_n0), 32'd1);
        checkOutput("async rst w_addr", 32'(w_addr0), 32'd0);
        checkOutput("async rst busy", 32'(busy0), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        applyStimulus(1'b0, '0, 1'b0, 8'h00, 1'b0);
        expectHold("post rst idle", 8'h00, 32'h0000_0000);
        applyStimulus(1'b1, pack(18'h00009, 18'h0000A, 18'h0000B, 18'h0000C), 1'b0, 8'h00, 1'b0);
        expectWrite("post rst w0", 8'h00, 32'h0000_0009, 1'b0, 1'b0);
        applyStimulus(1'b0, '0, 1'b0, 8'h00, 1'b0);
        expectWrite("post rst w1", 8'h01, 32'h0000_000A, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
